generic_fifo: RTL and testbench
===============================

Name: generic_fifo

Overview:
Parametrised single-clock synchronous FIFO that supersedes the fixed 8x64 control-plus-memory pairing in the generic router datapath. Storage, pointer control and status are one block. It supports any DEPTH >= 2 (not restricted to a power of two) and any WIDTH. It adds a registered read port, programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags.

Parameters:
WIDTH, 64, data word width in bits (>= 1)
DEPTH, 8, number of entries (>= 2, any integer)
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
CW, $clog2(DEPTH+1), derived count width; not overridden

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
push  input  1  write request; wr_data captured when accepted
wr_data  input  WIDTH  write data
pop  input  1  read request
rd_data  output  WIDTH  registered read data
rd_valid  output  1  high for one cycle when rd_data carries a newly popped word
flush  input  1  synchronous empty-the-FIFO command
clr_err  input  1  synchronous clear of sticky error flags
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  CW  current occupancy, 0..DEPTH
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (reset low, asynchronous): wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, rd_valid = 0, rd_data = 0, overflow = underflow = 0. Memory array is not reset. Release is synchronous to clk.
- All status outputs are functions of registered state only. No combinational path from push or pop to any output.
- Acceptance is evaluated on the state before the edge:
  - push_ok = push & ~full
  - pop_ok = pop & ~empty
- push_ok: mem[wr_ptr] <= wr_data; wr_ptr advances, wrapping DEPTH-1 -> 0.
- pop_ok: rd_data <= mem[rd_ptr]; rd_valid <= 1 next cycle; rd_ptr advances with the same wrap. Read latency is 1 cycle from pop to rd_data/rd_valid.
- No pop_ok: rd_valid <= 0 and rd_data holds its last value.
- Count update:
  - push_ok only: +1
  - pop_ok only: -1
  - both: unchanged
- Full with push and pop in the same cycle: the pop is accepted and the push is rejected; overflow sets and count becomes DEPTH-1.
- Empty with push and pop in the same cycle: the push is accepted and the pop is rejected; underflow sets, count becomes 1, rd_valid stays 0. There is no fall-through.
- Error flags:
  - push & full sets overflow; pop & empty sets underflow.
  - Both remain set until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the set wins.
- flush has priority over push and pop:
  - Pointers and count go to 0 and rd_valid goes to 0.
  - push/pop in that cycle are ignored and raise no errors.
  - rd_data holds; error flags are unaffected.
- Flags on wrap: full, empty and count must be correct when pointers are equal, for both full and empty cases, including non-power-of-two DEPTH.
- Reset asserted mid-operation: all state returns to reset values immediately; data in flight is discarded.

Test Plan:
- Reset/defaults: hold reset low, then release -> empty=1, almost_empty=1, full=0, count=0, rd_valid=0, rd_data=0, no errors.
- Fill/drain ordering, WIDTH=64, DEPTH=8:
  - push 0x1..0x8 -> full=1, count=8, almost_full from count 6.
  - pop 8 times -> rd_data 0x1..0x8, each one cycle after its pop; empty=1 after the last.
- Non-power-of-two, DEPTH=5: 3 laps of continuous push/pop with an offset of 2 -> data order preserved across pointer wrap; count never exceeds 5.
- Boundary collisions:
  - full + push + pop -> overflow=1, count=4 (DEPTH=5), oldest word returned.
  - empty + push + pop -> underflow=1, count=1, rd_valid=0.
- Sticky errors and flush:
  - errors persist over 10 idle cycles and clear on clr_err.
  - flush at count=3 with push=1 -> count=0, empty=1 next cycle, no error set.
- Async reset mid-stream: assert reset between clock edges at count=4 -> outputs return to reset values before the next edge; afterwards push 0xAA then pop -> rd_data=0xAA.

Source files
------------

// File: rtl/generic_fifo.sv
// Parametrised single-clock FIFO with a registered read port, occupancy count,
// programmable almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module generic_fifo #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             flush,
    input  logic             clr_err,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = $clog2(DEPTH);

    // Pointers wrap at DEPTH-1 so non-power-of-two depths never index past the array.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]    count_r, count_next_s;
    logic [WIDTH-1:0] rd_data_r;
    logic             rd_valid_r, full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
    logic             push_ok_s, pop_ok_s, ovf_next_s, unf_next_s;

    // Acceptance, next occupancy and next error state, all from pre-edge registered state.
    always_comb begin
        push_ok_s    = push & ~full_r & ~flush;
        pop_ok_s     = pop & ~empty_r & ~flush;
        count_next_s = count_r;
        ovf_next_s   = ovf_r;
        unf_next_s   = unf_r;
        if (flush) begin
            count_next_s = {CW{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_next_s = count_r + CW'(1);
                2'b01:   count_next_s = count_r - CW'(1);
                default: count_next_s = count_r;
            endcase
        end
        // A new error in the same cycle as clr_err keeps the flag set.
        if (~flush & push & full_r) begin
            ovf_next_s = 1'b1;
        end else if (clr_err) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
        if (~flush & pop & empty_r) begin
            unf_next_s = 1'b1;
        end else if (clr_err) begin
            unf_next_s = 1'b0;
        end else begin
            unf_next_s = unf_r;
        end
    end

    // Storage array, deliberately left without reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy, registered status flags, read port and sticky errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            af_r       <= 1'b0;
            ae_r       <= 1'b1;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {WIDTH{1'b0}};
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_r <= {PW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
            end else begin
                if (push_ok_s) begin
                    wr_ptr_r <= ptr_inc(wr_ptr_r);
                end
                if (pop_ok_s) begin
                    rd_ptr_r  <= ptr_inc(rd_ptr_r);
                    rd_data_r <= mem_r[rd_ptr_r];
                end
            end
            rd_valid_r <= pop_ok_s;
            count_r    <= count_next_s;
            full_r     <= (count_next_s == CW'(DEPTH));
            empty_r    <= (count_next_s == {CW{1'b0}});
            af_r       <= (count_next_s >= CW'(AF_LEVEL));
            ae_r       <= (count_next_s <= CW'(AE_LEVEL));
            ovf_r      <= ovf_next_s;
            unf_r      <= unf_next_s;
        end
    end

    assign rd_data      = rd_data_r;
    assign rd_valid     = rd_valid_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign count        = count_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;

endmodule

// File: tb/tb_generic_fifo.sv
// Bench for generic_fifo: a DEPTH=8 and a DEPTH=5 instance share one stimulus
// stream and are both compared each cycle against queue-based reference models.
module tb_generic_fifo;

    logic        clk = 1'b0;
    logic        reset, push, pop, flush, clr_err;
    logic [63:0] wr_data;

    logic [63:0] rd_data8, rd_data5;
    logic        rd_valid8, full8, empty8, af8, ae8, ovf8, unf8;
    logic        rd_valid5, full5, empty5, af5, ae5, ovf5, unf5;
    logic [3:0]  count8;
    logic [2:0]  count5;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    generic_fifo #(.WIDTH(64), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) u_d8 (
        .clk(clk), .reset(reset), .push(push), .wr_data(wr_data), .pop(pop),
        .rd_data(rd_data8), .rd_valid(rd_valid8), .flush(flush), .clr_err(clr_err),
        .full(full8), .empty(empty8), .almost_full(af8), .almost_empty(ae8),
        .count(count8), .overflow(ovf8), .underflow(unf8)
    );

    generic_fifo #(.WIDTH(64), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_d5 (
        .clk(clk), .reset(reset), .push(push), .wr_data(wr_data), .pop(pop),
        .rd_data(rd_data5), .rd_valid(rd_valid5), .flush(flush), .clr_err(clr_err),
        .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5),
        .count(count5), .overflow(ovf5), .underflow(unf5)
    );

    // Reference model: one queue per instance plus expected read port and error flags.
    int          depth_m [2] = '{8, 5};
    int          af_m    [2] = '{6, 4};
    int          ae_m    [2] = '{1, 1};
    logic [63:0] mq0 [$];
    logic [63:0] mq1 [$];
    logic        ovf_m [2];
    logic        unf_m [2];
    logic        rdv_m [2];
    logic [63:0] rdd_m [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int msize(input int i);
        return (i == 0) ? mq0.size() : mq1.size();
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int i = 0; i < 2; i++) begin
            ovf_m[i] = 1'b0; unf_m[i] = 1'b0; rdv_m[i] = 1'b0; rdd_m[i] = 64'd0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int  n;
            logic was_full, was_empty;
            n = msize(i);
            was_full  = (n == depth_m[i]);
            was_empty = (n == 0);
            if (flush) begin
                if (i == 0) mq0.delete(); else mq1.delete();
                rdv_m[i] = 1'b0;
            end else begin
                rdv_m[i] = pop && !was_empty;
                if (rdv_m[i]) rdd_m[i] = (i == 0) ? mq0.pop_front() : mq1.pop_front();
                if (push && !was_full) begin
                    if (i == 0) mq0.push_back(wr_data); else mq1.push_back(wr_data);
                end
            end
            if (!flush && push && was_full) ovf_m[i] = 1'b1;
            else if (clr_err) ovf_m[i] = 1'b0;
            if (!flush && pop && was_empty) unf_m[i] = 1'b1;
            else if (clr_err) unf_m[i] = 1'b0;
        end
    endtask

    task automatic check_one(input int i, input logic [63:0] cnt, input logic f, input logic e,
                             input logic af, input logic ae, input logic rv,
                             input logic [63:0] rd, input logic ov, input logic un);
        string p;
        int    n;
        p = $sformatf("d%0d_", depth_m[i]);
        n = msize(i);
        check({p, "count"}, cnt, 64'(n));
        check({p, "full"}, 64'(f), 64'(n == depth_m[i]));
        check({p, "empty"}, 64'(e), 64'(n == 0));
        check({p, "almost_full"}, 64'(af), 64'(n >= af_m[i]));
        check({p, "almost_empty"}, 64'(ae), 64'(n <= ae_m[i]));
        check({p, "rd_valid"}, 64'(rv), 64'(rdv_m[i]));
        check({p, "rd_data"}, rd, rdd_m[i]);
        check({p, "overflow"}, 64'(ov), 64'(ovf_m[i]));
        check({p, "underflow"}, 64'(un), 64'(unf_m[i]));
    endtask

    task automatic check_all();
        check_one(0, 64'(count8), full8, empty8, af8, ae8, rd_valid8, rd_data8, ovf8, unf8);
        check_one(1, 64'(count5), full5, empty5, af5, ae5, rd_valid5, rd_data5, ovf5, unf5);
    endtask

    task automatic cycle(input logic p, input logic q, input logic [63:0] d,
                         input logic f, input logic c);
        push = p; pop = q; wr_data = d; flush = f; clr_err = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [63:0] k;
        logic [63:0] oldest;
        reset = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; wr_data = 64'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        reset = 1'b1;
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check("rst_empty", 64'(empty8), 64'd1);
        check("rst_ae", 64'(ae8), 64'd1);

        // Fill and drain the DEPTH=8 instance in order.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 64'(i), 1'b0, 1'b0);
            check("fill_af", 64'(af8), 64'(i >= 6));
        end
        check("fill_full", 64'(full8), 64'd1);
        check("fill_count", 64'(count8), 64'd8);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, 64'd0, 1'b0, 1'b0);
            check("drain_data", rd_data8, 64'(i));
            check("drain_valid", 64'(rd_valid8), 64'd1);
        end
        check("drain_empty", 64'(empty8), 64'd1);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

        // Three laps of the DEPTH=5 pointers with an occupancy offset of 2.
        k = 64'h100;
        repeat (2) begin cycle(1'b1, 1'b0, k, 1'b0, 1'b0); k++; end
        repeat (15) begin
            cycle(1'b1, 1'b1, k, 1'b0, 1'b0); k++;
            check("lap_count_max", 64'(count5 <= 3'd5), 64'd1);
        end

        // Full collision on DEPTH=5.
        repeat (3) begin cycle(1'b1, 1'b0, k, 1'b0, 1'b0); k++; end
        check("d5_full_before", 64'(full5), 64'd1);
        oldest = mq1[0];
        cycle(1'b1, 1'b1, k, 1'b0, 1'b0); k++;
        check("full_coll_ovf", 64'(ovf5), 64'd1);
        check("full_coll_count", 64'(count5), 64'd4);
        check("full_coll_data", rd_data5, oldest);

        // Empty collision on DEPTH=5.
        repeat (4) cycle(1'b0, 1'b1, 64'd0, 1'b0, 1'b0);
        check("d5_empty_before", 64'(empty5), 64'd1);
        cycle(1'b1, 1'b1, k, 1'b0, 1'b0); k++;
        check("empty_coll_unf", 64'(unf5), 64'd1);
        check("empty_coll_count", 64'(count5), 64'd1);
        check("empty_coll_valid", 64'(rd_valid5), 64'd0);

        // Sticky errors survive idle cycles, then clear.
        repeat (10) begin
            cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
            check("sticky_ovf", 64'(ovf5), 64'd1);
            check("sticky_unf", 64'(unf5), 64'd1);
        end
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        check("clr_ovf", 64'(ovf5), 64'd0);
        check("clr_unf", 64'(unf5), 64'd0);

        // Flush at count 3 with a push pending.
        repeat (2) begin cycle(1'b1, 1'b0, k, 1'b0, 1'b0); k++; end
        check("d5_count3", 64'(count5), 64'd3);
        cycle(1'b1, 1'b0, k, 1'b1, 1'b0);
        check("flush_count", 64'(count5), 64'd0);
        check("flush_empty", 64'(empty5), 64'd1);
        check("flush_ovf", 64'(ovf5), 64'd0);

        // Randomised traffic with occasional flush and error clear.
        repeat (400) begin
            cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                  {$urandom, $urandom}, 1'($urandom_range(0, 99) < 3),
                  1'($urandom_range(0, 99) < 5));
        end

        // Asynchronous reset between edges at count 4.
        cycle(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        repeat (4) begin cycle(1'b1, 1'b0, k, 1'b0, 1'b0); k++; end
        check("arst_pre_count", 64'(count8), 64'd4);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        check("arst_count", 64'(count8), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 64'hAA, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 64'd0, 1'b0, 1'b0);
        check("arst_data", rd_data8, 64'hAA);
        check("arst_valid", 64'(rd_valid8), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
